// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker_core fetch stage.
package tinker_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h2000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 64'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Small instruction buffer: power-of-two depth, synchronous flush, registered head.
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] CAP = OW'(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_en, pop_en;

  assign empty   = (occ == '0);
  assign pop_en  = pop && !empty;
  // A full buffer can still take a write when the head leaves in the same cycle.
  assign push_en = push && ((occ != CAP) || pop_en);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      if (push_en && !pop_en)      occ <= occ + OW'(1);
      else if (pop_en && !push_en) occ <= occ - OW'(1);
    end
  end

endmodule

// File: rtl/tinker_fetch.sv
// Instruction fetch: owns the PC, issues one word read at a time, buffers
// returned words with their PC and hands them to the decoder.
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW:0] CAP = (OW+1)'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, req_pc_q;
  logic [OW-1:0]     occ;
  logic              empty, credit, credit_after;
  logic              req_fire, push, pop;
  fetch_entry_t      head;

  // Credit counts the outstanding request so the buffer can never overflow.
  assign credit       = ({1'b0, occ} + (OW+1)'(state_q == WAIT)) < CAP;
  assign credit_after = ({1'b0, occ} + (OW+1)'(1) - (OW+1)'(pop)) < CAP;

  assign mem_req_valid = !reset && (state_q == REQ) && !halt && credit;
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Redirect wins over push, pop and the request handshake.
  assign push = (state_q == WAIT) && mem_resp_valid && !redirect_valid;
  assign pop  = !empty && instr_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      case (state_q)
        // A response landing with the redirect closes the in-flight request.
        WAIT, DROP: state_d = mem_resp_valid ? REQ : DROP;
        REQ:        state_d = req_fire ? DROP : REQ;
        default:    state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: if (credit && !halt) state_d = REQ;
        REQ: begin
          if (req_fire)           state_d = WAIT;
          else if (!mem_req_valid) state_d = IDLE;
        end
        WAIT: if (mem_resp_valid) state_d = (credit_after && !halt) ? REQ : IDLE;
        DROP: if (mem_resp_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q <= align_pc(redirect_pc);
      end else if (req_fire) begin
        pc_q     <= pc_q + PC_STEP;
        req_pc_q <= pc_q;
      end
    end
  end

  tinker_fetch_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{instr: mem_resp_data, pc: req_pc_q}),
    .rdata (head),
    .empty (empty),
    .occ   (occ)
  );

  assign instr_valid = !empty;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

  // Memory must only answer while a request is in flight.
  resp_only_when_outstanding: assert property (@(posedge clk) disable iff (reset)
    !(mem_resp_valid && (state_q == IDLE || state_q == REQ)));

endmodule

// File: tb/tb_tinker_fetch.sv
// Directed bench for tinker_fetch with a latency-programmable memory model
// and an instruction scoreboard checked by an independent monitor.
module tb_tinker_fetch;
  import tinker_pkg::*;

  logic        clk = 0, reset = 0, halt = 1, redirect_valid = 0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid, mem_req_ready = 0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;

  int checks = 0, errors = 0;
  int cyc = 0, first_req = -1, first_vld = -1;
  int lat = 1, cnt = 0;
  logic [63:0]  pend_addr;
  fetch_entry_t exp_q[$];
  logic [63:0]  req_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tinker_fetch dut (
    .clk(clk), .reset(reset), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: answers each accepted request exactly once, lat cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      cnt            <= 0;
    end else if (mem_req_valid && mem_req_ready) begin
      pend_addr <= mem_req_addr;
      if (lat <= 1) begin
        mem_resp_valid <= 1'b1;
        mem_resp_data  <= word(mem_req_addr);
      end else begin
        mem_resp_valid <= 1'b0;
        cnt            <= lat - 1;
      end
    end else if (cnt != 0) begin
      cnt            <= cnt - 1;
      mem_resp_valid <= (cnt == 1);
      mem_resp_data  <= word(pend_addr);
    end else begin
      mem_resp_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_req(input string nm, input int idx, input logic [63:0] exp);
    if (idx < req_log.size()) chk(nm, req_log[idx], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=%0h", nm, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] a);
    exp_q.push_back('{instr: word(a), pc: a});
  endtask

  // Scoreboard monitor: logs requests, checks every consumed instruction.
  always @(negedge clk) begin
    if (reset) begin
      req_log.delete();
      first_req = -1;
      first_vld = -1;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        if (first_req < 0) first_req = cyc;
        req_log.push_back(mem_req_addr);
      end
      if (instr_valid && first_vld < 0) first_vld = cyc;
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr actual_pc=%0h required=none", instr_pc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_out", {32'h0, instr_out}, {32'h0, e.instr});
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at the drive point of the first cycle after reset release.
  task automatic do_reset();
    reset = 1; halt = 1; instr_ready = 0; mem_req_ready = 0;
    redirect_valid = 0; lat = 1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    // reset values
    #1 reset = 1;
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 64'h2000);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_pc", instr_pc, 0);

    // streaming: three sequential fetches, latency 2 from request to instr_valid
    do_reset();
    halt = 0; mem_req_ready = 1; instr_ready = 1;
    push_exp(64'h2000); push_exp(64'h2004); push_exp(64'h2008);
    cycles(5); halt = 1;
    cycles(6);
    chk("p1_req_count", req_log.size(), 3);
    chk_req("p1_req0", 0, 64'h2000);
    chk_req("p1_req1", 1, 64'h2004);
    chk_req("p1_req2", 2, 64'h2008);
    chk("p1_latency", first_vld - first_req, 2);
    chk("p1_drained", exp_q.size(), 0);

    // backpressure: buffer fills to DEPTH, fetch idles, then resumes at 0x2008
    do_reset();
    halt = 0; mem_req_ready = 1; instr_ready = 0;
    push_exp(64'h2000); push_exp(64'h2004); push_exp(64'h2008);
    cycles(10);
    @(negedge clk);
    chk("p2_full_no_req", mem_req_valid, 0);
    chk("p2_full_valid", instr_valid, 1);
    chk("p2_full_head", instr_pc, 64'h2000);
    chk("p2_full_reqs", req_log.size(), 2);
    cycles(1); instr_ready = 1;
    cycles(3); halt = 1;
    cycles(5);
    chk("p2_req_count", req_log.size(), 3);
    chk_req("p2_resume", 2, 64'h2008);
    chk("p2_drained", exp_q.size(), 0);

    // redirect while waiting on a slow response
    do_reset();
    halt = 0; mem_req_ready = 1; instr_ready = 1; lat = 3;
    cycles(1);
    redirect_valid = 1; redirect_pc = 64'h3003; exp_q.delete();
    cycles(1); redirect_valid = 0; lat = 1;
    push_exp(64'h3000);
    @(negedge clk);
    chk("p3_drop_no_req", mem_req_valid, 0);
    cycles(2);
    @(negedge clk);
    chk("p3_new_req_valid", mem_req_valid, 1);
    chk("p3_new_req_addr", mem_req_addr, 64'h3000);
    cycles(1); halt = 1;
    cycles(5);
    chk("p3_req_count", req_log.size(), 2);
    chk_req("p3_req_old", 0, 64'h2000);
    chk_req("p3_req_new", 1, 64'h3000);
    chk("p3_drained", exp_q.size(), 0);

    // redirect colliding with a request handshake and a pop
    do_reset();
    halt = 0; mem_req_ready = 1; instr_ready = 1;
    cycles(2);
    redirect_valid = 1; redirect_pc = 64'h4000; exp_q.delete();
    @(negedge clk);
    chk("p4_hs_valid", mem_req_valid, 1);
    chk("p4_pop_valid", instr_valid, 1);
    chk("p4_pop_pc", instr_pc, 64'h2000);
    cycles(1); redirect_valid = 0;
    push_exp(64'h4000);
    @(negedge clk);
    chk("p4_flushed", instr_valid, 0);
    chk("p4_drop_no_req", mem_req_valid, 0);
    cycles(1);
    @(negedge clk);
    chk("p4_target_valid", mem_req_valid, 1);
    chk("p4_target_addr", mem_req_addr, 64'h4000);
    cycles(1); halt = 1;
    cycles(5);
    chk("p4_req_count", req_log.size(), 3);
    chk("p4_drained", exp_q.size(), 0);

    // request held stable under memory backpressure, then halt drains
    do_reset();
    halt = 0; mem_req_ready = 0; instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("p5_hold_valid", mem_req_valid, 1);
      chk("p5_hold_addr", mem_req_addr, 64'h2000);
      cycles(1);
    end
    mem_req_ready = 1; push_exp(64'h2000);
    cycles(1); halt = 1;
    cycles(5);
    @(negedge clk);
    chk("p5_halt_no_req", mem_req_valid, 0);
    chk("p5_halt_buffered", instr_valid, 1);
    cycles(1); instr_ready = 1;
    cycles(4);
    @(negedge clk);
    chk("p5_halt_empty", instr_valid, 0);
    chk("p5_req_count", req_log.size(), 1);
    chk("p5_drained", exp_q.size(), 0);

    // async reset in WAIT with one buffered entry
    do_reset();
    halt = 0; mem_req_ready = 1; instr_ready = 0;
    cycles(2); lat = 5;
    cycles(1);
    @(negedge clk);
    chk("p6_pre_buffered", instr_valid, 1);
    #2 reset = 1;
    exp_q.delete();
    #1;
    chk("p6_rst_req_valid", mem_req_valid, 0);
    chk("p6_rst_req_addr", mem_req_addr, 64'h2000);
    chk("p6_rst_instr_valid", instr_valid, 0);
    chk("p6_rst_instr_out", instr_out, 0);
    chk("p6_rst_instr_pc", instr_pc, 0);
    @(posedge clk); @(posedge clk);
    #1 reset = 0;
    lat = 1; instr_ready = 1;
    push_exp(64'h2000);
    cycles(1); halt = 1;
    cycles(5);
    chk("p6_req_count", req_log.size(), 1);
    chk_req("p6_first_req", 0, 64'h2000);
    chk("p6_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinker_fetch.md
Name: tinker_fetch

Overview:
- Instruction-fetch stage of tinker_core, directly upstream of instruction_decoder.
- Owns the 64-bit PC and issues 32-bit instruction reads over a valid/ready memory port.
- Buffers returned words with their PC in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts redirects (branch/jump) that flush all in-flight and buffered work.

Parameters:
- RESET_PC, 64'h2000, PC loaded on reset.
- DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- halt  in  1  when 1, no new memory request is issued; in-flight work completes.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  64  new PC; bits [1:0] are ignored and forced to 0.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  64  byte address of the requested word.
- mem_resp_valid  in  1  read data valid; pulses exactly once per accepted request, at least 1 cycle after acceptance.
- mem_resp_data  in  32  instruction word.
- instr_valid  out  1  instr_out/instr_pc hold a valid entry.
- instr_ready  in  1  decoder consumes the entry.
- instr_out  out  32  instruction to decoder (opcode in [31:27]).
- instr_pc  out  64  address of instr_out.

Behaviour:
- Reset (async): pc=RESET_PC, state=REQ, buffer empty, outstanding=0.
  - Outputs during reset: mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
- At most one outstanding memory request.
- Credit rule: mem_req_valid=1 only in REQ with !halt and (occupancy + outstanding) < DEPTH. The buffer can therefore never overflow.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: entered when there is no credit or halt=1. Moves to REQ on the cycle after credit returns and halt=0.
  - REQ: mem_req_addr=pc. On valid&&ready: pc<=pc+4 (wraps modulo 2^64), go to WAIT.
  - WAIT: on mem_resp_valid, push {mem_resp_data, req_pc} into the buffer, then go to REQ (or IDLE if no credit or halt).
  - DROP: a redirected request is still in flight. On mem_resp_valid, discard the data and go to REQ.
- Request stability: while mem_req_valid && !mem_req_ready, the address is held stable. Only a redirect may withdraw or change it.
- Redirect priority: redirect beats push, pop and handshake in the same cycle.
  - Buffer flushed (occupancy 0); instr_valid=0 next cycle.
  - pc<=redirect_pc with [1:0] cleared.
  - From WAIT, or from REQ with the handshake in the same cycle: go to DROP.
  - From IDLE, or REQ without a handshake: go to REQ.
  - From DROP: stay in DROP.
  - The first request at the new PC is issued no earlier than the cycle after the redirect.
- mem_resp_valid in IDLE or REQ is a protocol error: ignore it and flag it via a simulation assertion.
- Buffer behaviour:
  - instr_valid = !empty; the head entry drives instr_out/instr_pc.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop is allowed at any occupancy, and occupancy is unchanged.
  - Outputs are registered from buffer storage, with no combinational path from mem_resp_* to instr_*.
- Latency: with memory ready=1 and response 1 cycle after acceptance:
  - request at cycle n, response at n+1, instr_valid at n+2.
  - peak throughput is 1 instruction per 2 cycles.
- halt does not flush; buffered entries still drain to the decoder.
- Reset mid-operation: the in-flight response is not tracked. The memory model must also be reset by the same reset.

Decomposition:
- Package tinker_pkg:
  - INSTR_W=32, ADDR_W=64, RESET_PC_DEFAULT=64'h2000, PC_STEP=4.
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP}.
  - fetch_entry_t struct {instr[31:0], pc[63:0]}.
- One sub-module, tinker_fetch_fifo: parameterised DEPTH, push/pop/flush, occupancy output, synchronous flush, async reset.

Test Plan:
- Reset release, memory ready=1, 1-cycle response, instr_ready=1 → requests at 0x2000, 0x2004, 0x2008; instr_pc sequence matches; instr_valid 2 cycles after the first request.
- instr_ready=0 for 10 cycles → exactly 2 entries buffered, mem_req_valid=0 (IDLE). Then ready=1 → both drain in order, and fetch resumes at 0x2008.
- Redirect to 0x3003 while in WAIT (response returns 3 cycles later) → that response is discarded, the next request is 0x3000, first instr_pc=0x3000, and no stale word reaches the decoder.
- Redirect in the same cycle as a REQ handshake and an instr_valid&&instr_ready pop → buffer empty next cycle, state DROP, next request to the redirect target.
- mem_req_ready held 0 for 5 cycles → mem_req_addr stays 0x2000 with mem_req_valid=1 throughout. halt=1 afterwards → no new request, and buffered entries still drain.
- Async reset asserted mid-WAIT with 1 buffered entry → outputs reach reset values immediately; after release, the first request is 0x2000.
